braun_product_accumulator: RTL and testbench

- Downstream stage of the combinational n x n unsigned Braun multiplier.
- Registers each 2N-bit product and accumulates a packet of products into a wider sum, for dot-product and MAC use.
- Upstream side uses a valid/ready handshake with a last-term marker.
- Downstream side holds each finished sum, term count and overflow flag until acknowledged.

---
 rtl/braun_product_accumulator.sv | 130 +++++++++++++
 tb/tb_braun_product_accumulator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/braun_product_accumulator.sv
// braun_product_accumulator
// Registers and accumulates 2N-bit products from an unsigned Braun multiplier
// into packet sums. Input is a valid/ready stream with a last-term marker, and
// each finished sum is held with its term count and overflow flag until acked.
// Optional build macro: BRAUN_ACC_SATURATE_EN (saturating accumulator; wraps
// modulo 2^AW when undefined).
module braun_product_accumulator #(
    parameter int unsigned N     = 4,
    parameter int unsigned G     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*N-1:0]       prod_in,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic                 clr,
    output logic [2*N+G-1:0]     acc_out,
    output logic [CNT_W-1:0]     term_cnt,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned AW = PW + G;
    localparam int unsigned SW = AW + 1;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Running packet state and presented result share one layout
    typedef struct packed {
        logic [AW-1:0]    acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } acc_state_t;

    state_e     state_q, state_d;
    acc_state_t run_q, run_d;
    acc_state_t res_q, res_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;

    logic             accept_c;
    acc_state_t       base_c;
    logic [SW-1:0]    sum_c;
    logic             carry_c;
    acc_state_t       next_c;

    // Beat acceptance depends on state only (in_ready mirrors state==ACC)
    assign accept_c = in_valid & in_ready_q;

    // Datapath: clr discards the partial packet before adding this beat
    always_comb begin
        base_c  = clr ? '0 : run_q;
        sum_c   = {1'b0, base_c.acc} + SW'(prod_in);
        carry_c = sum_c[AW];
`ifdef BRAUN_ACC_SATURATE_EN
        next_c.acc = (carry_c || (base_c.acc == {AW{1'b1}})) ? {AW{1'b1}} : sum_c[AW-1:0];
`else
        next_c.acc = sum_c[AW-1:0];
`endif
        next_c.cnt = (base_c.cnt == {CNT_W{1'b1}}) ? base_c.cnt : base_c.cnt + CNT_W'(1);
        next_c.ovf = base_c.ovf | carry_c;
    end

    // Next-state and register updates for ACC/HOLD
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_ACC: begin
                if (accept_c) begin
                    if (in_last) begin
                        res_d       = next_c;
                        out_valid_d = 1'b1;
                        run_d       = '0;
                        state_d     = ST_HOLD;
                    end else begin
                        run_d = next_c;
                    end
                end else if (clr) begin
                    run_d = '0;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase

        in_ready_d = (state_d == ST_ACC);
    end

    // State and datapath registers, async active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            run_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign acc_out   = res_q.acc;
    assign term_cnt  = res_q.cnt;
    assign ovf       = res_q.ovf;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_braun_product_accumulator.sv
// Self-checking bench for braun_product_accumulator (N=4, G=4, CNT_W=8).
module tb_braun_product_accumulator;

    localparam int unsigned N     = 4;
    localparam int unsigned G     = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned AW    = 2 * N + G;
    localparam int          BUDGET = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2*N-1:0]   prod_in = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             clr = 1'b0;
    logic [AW-1:0]    acc_out;
    logic [CNT_W-1:0] term_cnt;
    logic             ovf;
    logic             out_valid;
    logic             out_ready = 1'b0;

    braun_product_accumulator #(.N(N), .G(G), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod_in   (prod_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .clr       (clr),
        .acc_out   (acc_out),
        .term_cnt  (term_cnt),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned acc;
        int unsigned cnt;
        int unsigned ovf;
    } exp_t;

    typedef struct {
        int          nbeats;
        int unsigned first_val;
        int unsigned last_val;
        logic        clr_on_last;
        exp_t        exp;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Scoreboard: compare each result on the cycle it is acknowledged
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got acc %0d with empty scoreboard", acc_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_acc_out", 32'(acc_out), e.acc);
                check("sb_term_cnt", 32'(term_cnt), e.cnt);
                check("sb_ovf", 32'(ovf), e.ovf);
            end
        end
    end

    // Drive one beat; returns at posedge+1 after it is accepted
    task automatic send_beat(input int unsigned v, input logic last, input logic c);
        int w;
        w = 0;
        in_valid = 1'b1;
        prod_in  = (2*N)'(v);
        in_last  = last;
        clr      = c;
        @(negedge clk);
        while (!in_ready && w < BUDGET) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready got 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic push_exp(input int unsigned a, input int unsigned c, input int unsigned o);
        exp_t e;
        e.acc = a;
        e.cnt = c;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < BUDGET) begin
            w++;
            @(posedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: pending %0d, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    vec_t vecs[9];

    initial begin
        // Packet table: {beats, value of non-last beats, last beat, clr on last, expected}
        vecs[0] = '{3,   225, 225, 1'b0, '{675, 3, 1}};
        vecs[0].exp.ovf = 0;
`ifdef BRAUN_ACC_SATURATE_EN
        vecs[1] = '{19,  225, 225, 1'b0, '{4095, 19, 1}};
        vecs[4] = '{17,  255, 255, 1'b0, '{4095, 17, 1}};
        vecs[8] = '{18,  255, 0,   1'b0, '{4095, 18, 1}};
`else
        vecs[1] = '{19,  225, 225, 1'b0, '{179, 19, 1}};
        vecs[4] = '{17,  255, 255, 1'b0, '{239, 17, 1}};
        vecs[8] = '{18,  255, 0,   1'b0, '{239, 18, 1}};
`endif
        vecs[2] = '{3,   100, 50,  1'b1, '{50, 1, 0}};
        vecs[3] = '{16,  255, 255, 1'b0, '{4080, 16, 0}};
        vecs[5] = '{1,   7,   7,   1'b0, '{7, 1, 0}};
        vecs[6] = '{300, 1,   1,   1'b0, '{300, 255, 0}};
        vecs[7] = '{2,   255, 0,   1'b0, '{255, 2, 0}};

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_acc_out", 32'(acc_out), 0);
        check("rst_term_cnt", 32'(term_cnt), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3 x 225, result visible right after the last accepting edge
        out_ready = 1'b0;
        send_beat(225, 1'b0, 1'b0);
        send_beat(225, 1'b0, 1'b0);
        send_beat(225, 1'b1, 1'b0);
        push_exp(675, 3, 0);
        check("lat_out_valid", 32'(out_valid), 1);
        check("lat_in_ready", 32'(in_ready), 0);
        check("lat_acc_out", 32'(acc_out), 675);

        // Stall in HOLD with a pending beat: nothing consumed, result stable
        in_valid = 1'b1;
        prod_in  = 8'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_acc_out", 32'(acc_out), 675);
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_out_valid", 32'(out_valid), 1);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ack_out_valid", 32'(out_valid), 0);
        check("ack_in_ready", 32'(in_ready), 1);
        // Stalled beat 9 must not have leaked into the next packet
        send_beat(7, 1'b1, 1'b0);
        push_exp(7, 1, 0);
        drain();

        // clr alone in ACC discards the partial packet
        send_beat(100, 1'b0, 1'b0);
        send_beat(100, 1'b0, 1'b0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        send_beat(30, 1'b1, 1'b0);
        push_exp(30, 1, 0);
        drain();

        // Async reset while holding a result
        out_ready = 1'b0;
        send_beat(5, 1'b1, 1'b0);
        check("pre_rst_out_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_acc_out", 32'(acc_out), 0);
        check("arst_term_cnt", 32'(term_cnt), 0);
        check("arst_ovf", 32'(ovf), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat(7, 1'b1, 1'b0);
        push_exp(7, 1, 0);
        drain();

        // clr during HOLD leaves the held result alone
        out_ready = 1'b0;
        send_beat(0, 1'b1, 1'b0);
        push_exp(0, 1, 0);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hclr_out_valid", 32'(out_valid), 1);
            check("hclr_acc_out", 32'(acc_out), 0);
            check("hclr_term_cnt", 32'(term_cnt), 1);
        end
        clr = 1'b0;
        out_ready = 1'b1;
        drain();

        // Table-driven packets, results checked by the scoreboard
        for (int v = 0; v < 9; v++) begin
            for (int b = 0; b < vecs[v].nbeats - 1; b++) begin
                send_beat(vecs[v].first_val, 1'b0, 1'b0);
            end
            push_exp(vecs[v].exp.acc, vecs[v].exp.cnt, vecs[v].exp.ovf);
            send_beat(vecs[v].last_val, 1'b1, vecs[v].clr_on_last);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
